// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the pipelined RV32 core: datapath width, the major
// opcodes the ID/EX register cares about, ALU operation classes and the
// layout of the 8-bit control bundle produced by the decode-stage control
// unit. Helper functions report which source registers an opcode reads.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_FUNCT  = 2'b10,
      ALUOP_RSVD   = 2'b11
   } aluop_e;

   // Bit 7 down to bit 0 of the control bundle, same packing on id_ctrl/ex_ctrl.
   localparam int CTRL_REGWRITE = 7;
   localparam int CTRL_ALUSRC   = 6;
   localparam int CTRL_ALUOP_HI = 5;
   localparam int CTRL_ALUOP_LO = 4;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_BRANCH   = 0;

   typedef struct packed {
      logic       regwrite;
      logic       alusrc;
      logic [1:0] aluop;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       branch;
   } ctrl_t;

   // R, S and B formats read rs1; loads read rs1; everything else reads neither.
   function automatic logic uses_rs1(input logic [6:0] opcode);
      return (opcode == OPC_R) || (opcode == OPC_LOAD) ||
             (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
   endfunction

   // Only R, S and B formats read rs2; a load's instr[24:20] is immediate bits.
   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OPC_R) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector. Raises hazard_stall when the
// instruction in EX is a load whose destination is a register the instruction
// in ID actually reads, so the load data cannot be forwarded in time.
// Ports:
//   id_valid, id_opcode, id_rs1, id_rs2 : instruction currently in ID
//   ex_valid, ex_rd, ex_memread         : instruction currently in EX
//   ex_flush                            : branch taken in EX, ID is discarded
//   hazard_stall                        : hold PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module hazard_detect
   import riscv_pkg::*;
(
   input  logic       id_valid,
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
   input  logic       ex_memread,
   input  logic       ex_flush,
   output logic       hazard_stall
);

   logic rs1_hit;
   logic rs2_hit;

   // A match only matters when ID really reads that register, and x0 is never
   // a real dependency. A flush wins because the ID instruction is being killed.
   always_comb begin
      rs1_hit      = uses_rs1(id_opcode) && (ex_rd == id_rs1);
      rs2_hit      = uses_rs2(id_opcode) && (ex_rd == id_rs2);
      hazard_stall = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
                     (rs1_hit || rs2_hit) && !ex_flush;
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register. Captures decoded operands and the control bundle
// from ID, inserts a bubble on a branch flush, a load-use hazard or an empty
// ID slot, and exposes the load-use stall to the upstream stages.
// Optional build macro: ID_EX_STATS_EN adds wrapping stall/flush counters;
// without it stall_cnt/flush_cnt are constant 0.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   id_*                          : decoded instruction from ID
//   ex_flush                      : branch taken in EX, discard ID instruction
//   hazard_stall                  : combinational load-use stall to IF/ID
//   ex_*                          : registered copies presented to EX
//   stall_cnt, flush_cnt          : statistics counters
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [6:0]       id_opcode,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [3:0]       id_funct,
   input  logic [7:0]       id_ctrl,
   input  logic             ex_flush,
   output logic             hazard_stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [3:0]       ex_funct,
   output logic [7:0]       ex_ctrl,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import riscv_pkg::*;

   ctrl_t ex_ctrl_q;
   logic  load_en;

   assign ex_ctrl = ex_ctrl_q;

   hazard_detect u_hazard_detect (
      .id_valid     (id_valid),
      .id_opcode    (id_opcode),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_memread   (ex_ctrl_q.memread),
      .ex_flush     (ex_flush),
      .hazard_stall (hazard_stall)
   );

   // Flush, stall and an empty ID slot all collapse to the same bubble, so the
   // priority order reduces to a single load enable.
   always_comb begin
      load_en = id_valid && !ex_flush && !hazard_stall;
   end

   // Pipeline register. A bubble zeroes every field, so stale operands never
   // reach the forwarding unit; a stalled instruction is simply re-presented
   // by ID next cycle rather than kept here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
         ex_ctrl_q   <= '0;
      end else if (load_en) begin
         ex_valid    <= 1'b1;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct    <= id_funct;
         ex_ctrl_q   <= ctrl_t'(id_ctrl);
      end else begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
         ex_ctrl_q   <= '0;
      end
   end

`ifdef ID_EX_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Event counters; a flush only counts when it actually kills a real
   // instruction in ID. Both wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (hazard_stall) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (ex_flush && id_valid) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
